// File: rtl/cache_fill_if.sv
// Cache-side fill request and memory-side bus for cache_fill_responder.
// master = responder side, slave = requester/memory side.
interface cache_fill_if;
   logic        cache_req;
   logic [31:0] cache_addr;
   logic        cache_burst;
   logic [2:0]  cache_burst_len;
   logic [15:0] cache_data;
   logic        cache_ack;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_burst;
   logic [2:0]  mem_len;
   logic        mem_grant;
   logic        mem_valid;
   logic [15:0] mem_rdata;

   modport master (
      input  cache_req, cache_addr, cache_burst, cache_burst_len,
      output cache_data, cache_ack,
      output mem_req, mem_addr, mem_burst, mem_len,
      input  mem_grant, mem_valid, mem_rdata
   );

   modport slave (
      output cache_req, cache_addr, cache_burst, cache_burst_len,
      input  cache_data, cache_ack,
      input  mem_req, mem_addr, mem_burst, mem_len,
      output mem_grant, mem_valid, mem_rdata
   );
endinterface

// File: rtl/cache_fill_responder.sv
// Line-fill engine: fetches len+1 16-bit words from memory (burst or per-word) and returns them to the cache.
// Optional response timeout with zero-fill abort is enabled by defining CACHE_FILL_TIMEOUT_EN.
module cache_fill_responder #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic         clk,
   input  logic         reset,
   cache_fill_if.master bus,
   output logic         busy,
   output logic         fill_err
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, HOLD = 2'd3} state_e;

   state_e      state_q, state_d;
   logic [31:0] base_q, base_d;
   logic        burst_q, burst_d;
   logic [2:0]  len_q, len_d;
   logic [3:0]  count_q, count_d;
   logic        hold_q, hold_d;
   logic        ack_q, ack_d;
   logic [15:0] data_q, data_d;
   logic [3:0]  words;
   logic        timeout;
   logic        flush;

   assign words = {1'b0, len_q} + 4'd1;

`ifdef CACHE_FILL_TIMEOUT_EN
   localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] tmo_q, tmo_d;
   logic          flush_q, flush_d;
   logic          err_q, err_d;
   logic          active, resp_seen;

   // The counter only runs while a memory response is still owed.
   always_comb begin
      active    = (state_q == REQ) || (state_q == WAIT && !flush_q && count_q != words);
      resp_seen = (state_q == REQ && bus.mem_grant) || (state_q == WAIT && bus.mem_valid);
      timeout   = active && !resp_seen && (tmo_q == TMO_LAST);
      tmo_d     = '0;
      if (active && !resp_seen) tmo_d = tmo_q + 1'b1;
      flush_d   = flush_q;
      if (timeout) flush_d = 1'b1;
      if (state_q == HOLD) flush_d = 1'b0;
      err_d     = err_q | timeout;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_q   <= '0;
         flush_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         tmo_q   <= tmo_d;
         flush_q <= flush_d;
         err_q   <= err_d;
      end
   end

   assign flush    = flush_q;
   assign fill_err = err_q;
`else
   logic unused_timeout_cycles;
   assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
   assign timeout  = 1'b0;
   assign flush    = 1'b0;
   assign fill_err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      burst_d = burst_q;
      len_d   = len_q;
      count_d = count_q;
      hold_d  = hold_q;
      ack_d   = 1'b0;
      data_d  = 16'h0000;
      case (state_q)
         IDLE: begin
            if (bus.cache_req) begin
               base_d  = {bus.cache_addr[31:4], 4'h0};
               burst_d = bus.cache_burst;
               len_d   = bus.cache_burst_len;
               count_d = 4'd0;
               state_d = REQ;
            end
         end
         REQ: begin
            if (timeout || bus.mem_grant) state_d = WAIT;
         end
         WAIT: begin
            // The cycle after the last word is the ack cycle; HOLD starts after it.
            if (count_q == words) begin
               state_d = HOLD;
               hold_d  = 1'b0;
            end else if (flush) begin
               ack_d   = 1'b1;
               count_d = count_q + 4'd1;
            end else if (!timeout && bus.mem_valid) begin
               ack_d   = 1'b1;
               data_d  = bus.mem_rdata;
               count_d = count_q + 4'd1;
               if (!burst_q && (count_q + 4'd1) != words) state_d = REQ;
            end
         end
         HOLD: begin
            hold_d = 1'b1;
            if (hold_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         base_q  <= 32'h0;
         burst_q <= 1'b0;
         len_q   <= 3'd0;
         count_q <= 4'd0;
         hold_q  <= 1'b0;
         ack_q   <= 1'b0;
         data_q  <= 16'h0000;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         burst_q <= burst_d;
         len_q   <= len_d;
         count_q <= count_d;
         hold_q  <= hold_d;
         ack_q   <= ack_d;
         data_q  <= data_d;
      end
   end

   // Memory request fields are decoded from state so reset clears them at once.
   assign bus.mem_req    = (state_q == REQ);
   assign bus.mem_addr   = (state_q == REQ) ? base_q + {27'd0, count_q, 1'b0} : 32'h0;
   assign bus.mem_burst  = (state_q == REQ) && burst_q;
   assign bus.mem_len    = (state_q == REQ && burst_q) ? len_q : 3'd0;
   assign bus.cache_ack  = ack_q;
   assign bus.cache_data = data_q;
   assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_cache_fill_responder.sv
// Scoreboard bench for cache_fill_responder: a memory model answers requests, a monitor checks grants and acks.
`timescale 1ns/1ps
module tb_cache_fill_responder;
   logic clk = 1'b0;
   logic reset;
   logic busy;
   logic fill_err;

   cache_fill_if bus();

   cache_fill_responder #(.TIMEOUT_CYCLES(16)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .busy     (busy),
      .fill_err (fill_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic        burst;
      logic [2:0]  len;
   } mreq_t;

   mreq_t       exp_mem[$];
   logic [15:0] exp_ack[$];
   int          checks = 0;
   int          errors = 0;
   int          acks_seen = 0;
   int          gnt_dly = -1;
   int          gap_max = 2;
   int          dmode_mem = 0;
   bit          mem_mute = 1'b0;
   logic        prev_vld = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s", name);
   endtask

   // Word content the memory holds at each address; independent of the design.
   function automatic logic [15:0] fdata(input logic [31:0] a);
      return a[15:0] ^ {a[23:16], a[31:24]} ^ 16'h3C5A;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: what a fill must produce, straight from the line/word rules.
   task automatic push_exp(input logic [31:0] a, input logic b, input logic [2:0] l, input int dm);
      logic [31:0] base;
      base = {a[31:4], 4'h0};
      if (b) exp_mem.push_back('{base, 1'b1, l});
      for (int i = 0; i <= int'(l); i++) begin
         if (!b) exp_mem.push_back('{base + 32'(2 * i), 1'b0, 3'd0});
         if (dm == 1)      exp_ack.push_back(16'hA000 + 16'(i));
         else if (dm == 2) exp_ack.push_back(16'h0000);
         else              exp_ack.push_back(fdata(base + 32'(2 * i)));
      end
   endtask

   task automatic fill_start(input logic [31:0] a, input logic b, input logic [2:0] l, input int dm);
      int n;
      push_exp(a, b, l, dm);
      bus.cache_addr      = a;
      bus.cache_burst     = b;
      bus.cache_burst_len = l;
      bus.cache_req       = 1'b1;
      n = 0;
      while (!busy && n < 10) begin
         tick();
         n++;
      end
      chk("busy_rise", busy, 1);
      // Request drops and fields change mid-fill; the latched fill must continue.
      bus.cache_req       = 1'b0;
      bus.cache_addr      = $urandom;
      bus.cache_burst     = 1'($urandom);
      bus.cache_burst_len = 3'($urandom);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while ((exp_ack.size() != 0 || busy) && n < 2000) begin
         tick();
         n++;
      end
      if (n >= 2000) fail_now("fill_completion_timeout");
      chk("mem_req_count_left", exp_mem.size(), 0);
   endtask

   task automatic fill(input logic [31:0] a, input logic b, input logic [2:0] l, input int dm);
      fill_start(a, b, l, dm);
      wait_done();
   endtask

   initial begin : mem_model
      logic [31:0] a;
      int n;
      int d;
      bus.mem_grant = 1'b0;
      bus.mem_valid = 1'b0;
      bus.mem_rdata = 16'h0000;
      forever begin
         tick();
         if (reset !== 1'b0 || bus.mem_req !== 1'b1) continue;
         a = bus.mem_addr;
         n = bus.mem_burst ? int'(bus.mem_len) + 1 : 1;
         d = (gnt_dly < 0) ? int'($urandom_range(0, 3)) : gnt_dly;
         for (int i = 0; i < d && reset == 1'b0; i++) tick();
         if (reset) continue;
         bus.mem_grant = 1'b1;
         tick();
         bus.mem_grant = 1'b0;
         if (mem_mute) continue;
         for (int k = 0; k < n; k++) begin
            d = int'($urandom_range(0, gap_max));
            for (int i = 0; i < d && reset == 1'b0; i++) tick();
            if (reset) break;
            bus.mem_valid = 1'b1;
            bus.mem_rdata = (dmode_mem == 1) ? 16'hA000 + 16'(k) : fdata(a + 32'(2 * k));
            tick();
            bus.mem_valid = 1'b0;
         end
      end
   end

   initial begin : monitor
      mreq_t m;
      forever begin
         @(negedge clk);
         if (reset !== 1'b0) begin
            prev_vld = 1'b0;
            continue;
         end
         if (bus.mem_req && bus.mem_grant) begin
            if (exp_mem.size() == 0) fail_now("unexpected_mem_req");
            else begin
               m = exp_mem.pop_front();
               chk("mem_addr", bus.mem_addr, m.addr);
               chk("mem_burst", bus.mem_burst, m.burst);
               chk("mem_len", bus.mem_len, m.len);
            end
         end
         if (prev_vld) chk("ack_latency", bus.cache_ack, 1);
         if (bus.cache_ack) begin
            acks_seen++;
            if (exp_ack.size() == 0) fail_now("unexpected_cache_ack");
            else chk("cache_data", bus.cache_data, exp_ack.pop_front());
         end
         prev_vld = bus.mem_valid;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int n;
      reset               = 1'b1;
      bus.cache_req       = 1'b0;
      bus.cache_addr      = 32'h0;
      bus.cache_burst     = 1'b0;
      bus.cache_burst_len = 3'd0;
      repeat (2) tick();
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_cache_ack", bus.cache_ack, 0);
      chk("rst_cache_data", bus.cache_data, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_burst", bus.mem_burst, 0);
      chk("rst_mem_len", bus.mem_len, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fill_err", fill_err, 0);
      reset = 1'b0;
      tick();

      // Burst fill with cache_req held high across the HOLD window.
      gnt_dly   = 3;
      gap_max   = 0;
      dmode_mem = 1;
      push_exp(32'h0000_1236, 1'b1, 3'd7, 1);
      bus.cache_addr      = 32'h0000_1236;
      bus.cache_burst     = 1'b1;
      bus.cache_burst_len = 3'd7;
      bus.cache_req       = 1'b1;
      n = 0;
      while (exp_ack.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      chk("burst_drained", n < 200, 1);
      push_exp(32'h0000_1236, 1'b1, 3'd7, 1);
      chk("hold1_busy", busy, 1);
      chk("hold1_no_req", bus.mem_req, 0);
      tick();
      chk("hold2_busy", busy, 1);
      chk("hold2_no_req", bus.mem_req, 0);
      tick();
      chk("busy_fall_3_after_ack", busy, 0);
      chk("idle_no_req", bus.mem_req, 0);
      tick();
      chk("refill_req", bus.mem_req, 1);
      bus.cache_req = 1'b0;
      wait_done();

      // Per-word fills, including the top-of-address-space line.
      gnt_dly   = -1;
      gap_max   = 2;
      dmode_mem = 0;
      fill(32'h0000_2000, 1'b0, 3'd7, 0);
      fill(32'hFFFF_FFF0, 1'b0, 3'd7, 0);

      // Reset in the middle of a burst fill.
      acks_seen = 0;
      fill_start(32'h0000_3000, 1'b1, 3'd7, 0);
      n = 0;
      while (acks_seen < 3 && n < 500) begin
         tick();
         n++;
      end
      chk("third_ack_seen", acks_seen >= 3, 1);
      reset = 1'b1;
      #1;
      chk("midrst_mem_req", bus.mem_req, 0);
      chk("midrst_cache_ack", bus.cache_ack, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_mem_addr", bus.mem_addr, 0);
      exp_ack.delete();
      exp_mem.delete();
      repeat (3) tick();
      reset     = 1'b0;
      acks_seen = 0;
      repeat (12) tick();
      chk("no_ack_after_reset", acks_seen, 0);
      fill(32'h0000_4018, 1'b1, 3'd3, 0);

      // Randomized fills.
      for (int i = 0; i < 12; i++) begin
         fill($urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 0);
      end

`ifdef CACHE_FILL_TIMEOUT_EN
      mem_mute = 1'b1;
      fill(32'h0000_5000, 1'b1, 3'd7, 2);
      chk("timeout_fill_err", fill_err, 1);
      mem_mute = 1'b0;
`else
      chk("fill_err_stays_low", fill_err, 0);
`endif

      repeat (4) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/cache_fill_responder.md
CACHE_FILL_RESPONDER -- requirements
Module: cache_fill_responder

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the number of cycles allowed between consecutive memory responses before a fill is aborted.
REQ-002 clk  input  1  single clock, all state on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state.
REQ-004 cache_req  input  1  level request for a line fill from the CPU cache side.
REQ-005 cache_addr  input  32  fill address; bits [3:0] are ignored.
REQ-006 cache_burst  input  1  1 = one burst memory access, 0 = per-word memory accesses.
REQ-007 cache_burst_len  input  3  words per fill minus one (7 = 8 words).
REQ-008 cache_data  output  16  returned word, valid when cache_ack=1.
REQ-009 cache_ack  output  1  one-cycle pulse per delivered word.
REQ-010 mem_req  output  1  memory request, held until granted.
REQ-011 mem_addr  output  32  memory byte address.
REQ-012 mem_burst  output  1  burst access qualifier.
REQ-013 mem_len  output  3  burst length minus one; 0 for single-word accesses.
REQ-014 mem_grant  input  1  memory accepted the request this cycle.
REQ-015 mem_valid  input  1  mem_rdata is valid this cycle.
REQ-016 mem_rdata  input  16  memory read data.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 fill_err  output  1  sticky timeout flag, cleared only by reset.

Function
REQ-019 The FSM SHALL have states IDLE, REQ, WAIT and HOLD.
REQ-020 In IDLE with cache_req=1, the module SHALL latch the line base {cache_addr[31:4],4'h0}, cache_burst and cache_burst_len, clear the word count, and enter REQ.
REQ-021 In REQ, mem_req SHALL be 1. mem_addr SHALL be base+2*count. mem_burst and mem_len SHALL come from the latched values, with mem_len forced to 0 when not in burst mode.
REQ-022 REQ SHALL move to WAIT on the cycle mem_grant=1; mem_req SHALL drop the following cycle.
REQ-023 In WAIT, each mem_valid=1 SHALL produce cache_ack=1 and cache_data=mem_rdata on the next cycle, which is 1-cycle registered latency, and SHALL increment count.
REQ-024 Words SHALL be delivered in ascending address order from the line base, with no critical-word-first wrap.
REQ-025 In burst mode, WAIT SHALL accept len+1 mem_valid pulses for a single grant.
REQ-026 In non-burst mode, each mem_valid SHALL be followed by a return to REQ for the next word, until count reaches len+1.
REQ-027 After the last word is accepted, the FSM SHALL enter HOLD for exactly 2 cycles and then go to IDLE; cache_req SHALL be ignored in HOLD, which covers the requester's request-drop latency.
REQ-028 mem_valid SHALL be ignored in IDLE, REQ and HOLD, and mem_grant SHALL be ignored outside REQ.
REQ-029 A cache_req drop mid-fill SHALL NOT abort the fill; all len+1 words SHALL still be delivered.
REQ-030 The word count SHALL be 4 bits wide so that len=7 reaches 8 without wrapping.
REQ-031 The address increment SHALL be 32-bit modulo, wrapping at 0xFFFFFFFF.

Reset
REQ-032 Asserting reset SHALL immediately force: state=IDLE, mem_req=0, cache_ack=0, cache_data=0, mem_addr=0, mem_burst=0, mem_len=0, busy=0, fill_err=0, count=0.
REQ-033 Reset mid-fill SHALL discard the fill with no further cache_ack.
REQ-034 The first request after reset release SHALL be sampled no earlier than the first clock edge with reset=0.

Configuration
REQ-035 With macro CACHE_FILL_TIMEOUT_EN defined, a counter SHALL run in REQ and WAIT and reload on every mem_grant and on every mem_valid.
REQ-036 With CACHE_FILL_TIMEOUT_EN defined, on reaching TIMEOUT_CYCLES the module SHALL:
  - set fill_err=1;
  - deliver each remaining word as cache_data=16'h0000 with a cache_ack pulse on consecutive cycles;
  - then enter HOLD.
REQ-037 Without CACHE_FILL_TIMEOUT_EN, no counter SHALL exist, fill_err SHALL be tied to 0, and the module SHALL wait indefinitely.

Verification
REQ-038 Burst fill: cache_addr=0x00001236, burst=1, len=7, grant after 3 cycles, 8 back-to-back valids with data 0xA000..0xA007 -> one mem_req at 0x00001230 with mem_len=7; 8 acks, each 1 cycle after its valid, data in that order; busy falls 3 cycles after the last ack.
REQ-039 Non-burst fill: burst=0, len=7, base 0x00002000 -> 8 grants at 0x2000, 0x2002, ..., 0x200E with mem_len=0; 8 acks.
REQ-040 Hold window: cache_req kept high through and after the last ack -> no new mem_req during the 2 HOLD cycles; a new fill starts from IDLE afterwards.
REQ-041 Reset mid-fill: reset asserted after the 3rd ack -> mem_req and cache_ack are 0 in the same cycle; no further acks; the next request starts with count=0.
REQ-042 Timeout (macro defined, TIMEOUT_CYCLES=16): grant then no valids -> fill_err=1 after 16 cycles; 8 acks with data 0x0000; then IDLE.
REQ-043 Boundary: cache_addr=0xFFFFFFF0, burst=0, len=7 -> addresses 0xFFFFFFF0..0xFFFFFFFE; the count reaches 8 with no early termination.
